// File: rtl/reaction_timer_bcd.sv
// -----------------------------------------------------------------------------
// reaction_timer_bcd
//
// Timing engine of the reaction game. A start press arms the game and loads a
// pseudo-random delay (MIN_DELAY_MS plus a masked LFSR value). When the delay
// has elapsed, GO is lit and a 4-digit BCD millisecond counter runs until the
// player presses react. Pressing react before GO is a foul, which blanks the
// display. The count saturates at 9999 and flags a timeout.
//
// Parameters
//   TICK_DIV     clk cycles per 1 ms tick (>= 2)
//   MIN_DELAY_MS fixed part of the pre-GO delay in ms (1..65535)
//   RAND_MASK    AND-mask applied to the LFSR to form the random delay part
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high reset
//   start    start button level, synchronised to clk
//   react    react button level, synchronised to clk
//   go_led   high while in GO
//   foul     high while in FOUL
//   timeout  high in DONE when the count saturated at 9999
//   digit3   BCD thousands of ms (4'hF = blank)
//   digit2   BCD hundreds of ms
//   digit1   BCD tens of ms
//   digit0   BCD units of ms
// -----------------------------------------------------------------------------
module reaction_timer_bcd #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter logic [15:0] RAND_MASK    = 16'h07FF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       react,
  output logic       go_led,
  output logic       foul,
  output logic       timeout,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    GO,
    DONE,
    FOUL
  } state_t;

  state_t        state;
  logic          start_q;
  logic          react_q;
  logic [15:0]   lfsr;
  logic [CW-1:0] tick_cnt;
  logic [16:0]   delay;

  logic          start_press;
  logic          react_press;
  logic          tick;
  logic          lfsr_fb;
  logic [16:0]   delay_load;
  logic          at_max;
  logic [15:0]   bcd_inc;

  assign start_press = start & ~start_q;
  assign react_press = react & ~react_q;
  assign tick        = (tick_cnt == TICK_LAST);

  // Fibonacci taps 16,14,13,11; a non-zero seed keeps the register non-zero.
  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign delay_load = 17'(MIN_DELAY_MS) + {1'b0, lfsr & RAND_MASK};
  assign at_max     = (digit3 == 4'd9) && (digit2 == 4'd9) &&
                      (digit1 == 4'd9) && (digit0 == 4'd9);

  // BCD increment with ripple carry: each digit wraps 9->0 and carries on.
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise a latch is inferred.
  always_comb begin
    logic carry;
    bcd_inc = {digit3, digit2, digit1, digit0};
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd_inc[i*4 +: 4] == 4'd9) begin
          bcd_inc[i*4 +: 4] = 4'd0;
        end else begin
          bcd_inc[i*4 +: 4] = bcd_inc[i*4 +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in this block override the
  // defaults above them (used for the tick-counter clear on transitions).
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      start_q  <= 1'b1;  // a button held through reset release is not a press
      react_q  <= 1'b1;
      lfsr     <= 16'hACE1;
      tick_cnt <= '0;
      delay    <= '0;
      go_led   <= 1'b0;
      foul     <= 1'b0;
      timeout  <= 1'b0;
      digit3   <= 4'h0;
      digit2   <= 4'h0;
      digit1   <= 4'h0;
      digit0   <= 4'h0;
    end else begin
      start_q  <= start;
      react_q  <= react;
      lfsr     <= {lfsr[14:0], lfsr_fb};
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);

      unique case (state)
        IDLE, DONE, FOUL: begin
          if (start_press) begin
            state    <= WAIT;
            tick_cnt <= '0;
            delay    <= delay_load;
            go_led   <= 1'b0;
            foul     <= 1'b0;
            timeout  <= 1'b0;
            {digit3, digit2, digit1, digit0} <= 16'h0000;
          end
        end

        WAIT: begin
          // react takes priority over a coincident tick
          if (react_press) begin
            state    <= FOUL;
            tick_cnt <= '0;
            foul     <= 1'b1;
            {digit3, digit2, digit1, digit0} <= 16'hFFFF;
          end else if (tick) begin
            if (delay == 17'd1) begin
              state    <= GO;
              tick_cnt <= '0;
              go_led   <= 1'b1;
            end else begin
              delay <= delay - 17'd1;
            end
          end
        end

        GO: begin
          // react takes priority: no increment in the press cycle
          if (react_press) begin
            state    <= DONE;
            tick_cnt <= '0;
            go_led   <= 1'b0;
          end else if (tick) begin
            if (at_max) begin
              state    <= DONE;
              tick_cnt <= '0;
              go_led   <= 1'b0;
              timeout  <= 1'b1;
            end else begin
              {digit3, digit2, digit1, digit0} <= bcd_inc;
            end
          end
        end

        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer_bcd.sv
// -----------------------------------------------------------------------------
// tb_reaction_timer_bcd
//
// Directed testbench for reaction_timer_bcd with TICK_DIV=4, MIN_DELAY_MS=2,
// RAND_MASK=0, so the pre-GO delay is always 2 ticks = 8 cycles and each GO
// count step takes 4 cycles. Inputs are driven and outputs sampled 1 time unit
// after a rising edge.
// -----------------------------------------------------------------------------
module tb_reaction_timer_bcd;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       react;
  logic       go_led;
  logic       foul;
  logic       timeout;
  logic [3:0] digit3;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;

  logic [15:0] digits;
  assign digits = {digit3, digit2, digit1, digit0};

  int checks   = 0;
  int failures = 0;
  bit bad_code = 1'b0;

  reaction_timer_bcd #(
    .TICK_DIV    (4),
    .MIN_DELAY_MS(2),
    .RAND_MASK   (16'h0000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .react  (react),
    .go_led (go_led),
    .foul   (foul),
    .timeout(timeout),
    .digit3 (digit3),
    .digit2 (digit2),
    .digit1 (digit1),
    .digit0 (digit0)
  );

  always #5 clk = ~clk;

  // Watch for illegal digit codes: 10..14 never, 15 only while foul is high.
  always @(negedge clk) begin
    if (!reset) begin
      if ((digit3 inside {[4'd10:4'd14]}) || (digit2 inside {[4'd10:4'd14]}) ||
          (digit1 inside {[4'd10:4'd14]}) || (digit0 inside {[4'd10:4'd14]}))
        bad_code = 1'b1;
      if (!foul && ((digit3 == 4'hF) || (digit2 == 4'hF) ||
                    (digit1 == 4'hF) || (digit0 == 4'hF)))
        bad_code = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    // 1. Reset with both buttons held high
    reset = 1'b1;
    start = 1'b1;
    react = 1'b1;
    step(3);
    reset = 1'b0;
    check("rst_digits",  32'(digits),  32'h0000);
    check("rst_go",      32'(go_led),  32'd0);
    check("rst_foul",    32'(foul),    32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    step(12);
    check("held_no_edge_go",     32'(go_led), 32'd0);
    check("held_no_edge_digits", 32'(digits), 32'h0000);

    // 2. Normal round: GO 8 cycles after the press edge, react after 9 ticks
    start = 1'b0;
    react = 1'b0;
    step(1);
    press_start();
    step(7);
    check("round_go_early", 32'(go_led), 32'd0);
    step(1);
    check("round_go_rise", 32'(go_led), 32'd1);
    step(36);
    check("round_nine_ticks", 32'(digits), 32'h0009);
    react = 1'b1;
    step(1);
    react = 1'b0;
    check("round_result", 32'(digits), 32'h0009);
    check("round_go_off", 32'(go_led), 32'd0);
    step(20);
    check("round_hold", 32'(digits), 32'h0009);

    // 4. Foul: react 3 cycles after start
    press_start();
    step(2);
    react = 1'b1;
    step(1);
    react = 1'b0;
    check("foul_flag",   32'(foul),   32'd1);
    check("foul_blank",  32'(digits), 32'hFFFF);
    check("foul_go_off", 32'(go_led), 32'd0);
    step(10);
    check("foul_still_go_off", 32'(go_led), 32'd0);
    check("foul_held",         32'(foul),   32'd1);
    press_start();
    check("refire_foul_clr", 32'(foul),   32'd0);
    check("refire_digits",   32'(digits), 32'h0000);
    step(7);
    check("refire_go_early", 32'(go_led), 32'd0);
    step(1);
    check("refire_go_rise", 32'(go_led), 32'd1);

    // 3 + 5. BCD carries and saturation in this GO round
    step(40);
    check("bcd_0010", 32'(digits), 32'h0010);
    step(360);
    check("bcd_0100", 32'(digits), 32'h0100);
    step(3600);
    check("bcd_1000", 32'(digits), 32'h1000);
    step(4 * 8999);
    check("bcd_9999",       32'(digits),  32'h9999);
    check("bcd_9999_go",    32'(go_led),  32'd1);
    check("bcd_9999_no_to", 32'(timeout), 32'd0);
    step(4);
    check("sat_timeout", 32'(timeout), 32'd1);
    check("sat_go_off",  32'(go_led),  32'd0);
    check("sat_digits",  32'(digits),  32'h9999);
    step(8);
    check("sat_hold", 32'(digits), 32'h9999);

    // 5b. react on the same cycle as the 6th tick -> stays 0005
    press_start();
    check("restart_timeout_clr", 32'(timeout), 32'd0);
    check("restart_digits",      32'(digits),  32'h0000);
    step(8);
    check("race_go_rise", 32'(go_led), 32'd1);
    step(23);
    check("race_pre", 32'(digits), 32'h0005);
    react = 1'b1;
    step(1);
    react = 1'b0;
    check("race_result", 32'(digits), 32'h0005);
    check("race_go_off", 32'(go_led), 32'd0);

    // 6. Reset mid-GO at 0042 with react held high
    press_start();
    step(8);
    step(168);
    check("mid_count", 32'(digits), 32'h0042);
    react = 1'b1;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midrst_digits",  32'(digits),  32'h0000);
    check("midrst_go",      32'(go_led),  32'd0);
    check("midrst_foul",    32'(foul),    32'd0);
    check("midrst_timeout", 32'(timeout), 32'd0);
    step(10);
    check("midrst_idle_go",     32'(go_led), 32'd0);
    check("midrst_idle_foul",   32'(foul),   32'd0);
    check("midrst_idle_digits", 32'(digits), 32'h0000);
    // Still IDLE: a start press must give GO exactly 8 cycles later
    press_start();
    step(7);
    check("idle_confirm_early", 32'(go_led), 32'd0);
    step(1);
    check("idle_confirm_go", 32'(go_led), 32'd1);

    check("no_illegal_codes", 32'(bad_code), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reaction_timer_bcd.md
Name: reaction_timer_bcd

Overview:
Core timing engine of the reaction game.
- Arms on a start press and waits a pseudo-random delay, then lights the GO LED.
- Counts elapsed milliseconds in 4-digit BCD until the player presses react.
- Drives four BCD digits directly into the per-digit seven-segment decoders. Codes 0-9 display as numerals; code 4'hF displays as blank, which the decoder's default case already handles.

Parameters:
TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clock); minimum 2.
MIN_DELAY_MS, 1000, fixed part of the pre-GO delay in ms; range 1..65535.
RAND_MASK, 16'h07FF, AND-mask applied to the LFSR to form the random part of the delay.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  start button level, active-high, already synchronised to clk
react  in  1  react button level, active-high, already synchronised to clk
go_led  out  1  high while in GO
foul  out  1  high while in FOUL (react pressed before GO)
timeout  out  1  high in DONE when the count saturated at 9999
digit3  out  4  BCD thousands of ms
digit2  out  4  BCD hundreds of ms
digit1  out  4  BCD tens of ms
digit0  out  4  BCD units of ms

Behaviour:
- Decided interface: one clock, clk; reset is synchronous and active-high, port reset.
- All outputs are registered.
- Reset values: go_led=0, foul=0, timeout=0, all digits=4'h0, state=IDLE, tick counter=0, LFSR=16'hACE1.
- Edge detect: start_q/react_q hold the previous cycle's input levels.
  - Both reset to 1, so a button held through reset release produces no edge.
  - Press = input high while its _q is 0. Only presses cause transitions.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle including IDLE; never reaches zero.
- Tick: counter runs 0..TICK_DIV-1, and tick=1 in the cycle it equals TICK_DIV-1. Counter clears on every state change, so the first tick in a state comes TICK_DIV cycles after entry.
- IDLE:
  - start press -> WAIT.
  - Load delay = MIN_DELAY_MS + (lfsr & RAND_MASK); clear digits to 0000, foul and timeout.
  - react ignored.
- WAIT:
  - Each tick decrements delay; when a tick hits delay==1 -> GO. Delay is exactly `delay` ticks.
  - react press -> FOUL; react beats a tick in the same cycle.
  - start ignored.
- GO:
  - go_led=1.
  - Each tick: BCD increment with ripple carry; each digit wraps 9->0 and carries to the next.
  - react press -> DONE; react beats a tick in the same cycle, so no increment that cycle.
  - Tick while value is 9999 -> DONE with timeout=1; digits stay 9999.
  - start ignored.
- DONE:
  - go_led=0; digits hold the result.
  - start press -> WAIT: new delay loaded, digits cleared, timeout cleared.
- FOUL:
  - foul=1, go_led=0, all digits=4'hF (blank).
  - start press -> WAIT: foul cleared, digits cleared to 0000.
- Outputs update on the clock edge that performs the transition. Observers see the change one cycle after the press or tick cycle.
- Digits never hold values 10..14. Value 15 appears only in FOUL.
- Reset mid-operation returns to the reset values on the next edge regardless of state.

Test Plan:
All scenarios use TICK_DIV=4, MIN_DELAY_MS=2, RAND_MASK=0 unless noted.
1. Reset: assert reset 3 cycles with start=react=1 held, then release -> digits 0000, go_led=0, foul=0, timeout=0; no transition even though both buttons are high.
2. Normal round: start high 1 cycle -> go_led rises exactly 8 cycles after the press edge. React press after 9 ticks in GO -> digits 0,0,0,9; go_led=0; further ticks leave the value unchanged.
3. BCD carry: stay in GO and sample at 10, 100 and 1000 ticks -> digits read 0010, 0100, 1000, with no intermediate 10..15 codes ever observed.
4. Foul: react press 3 cycles after start -> foul=1, digits FFFF, go_led=0 (never goes high). Start press -> foul=0, digits 0000, go_led rises 8 cycles later.
5. Saturation and simultaneous events: no react for 9999 ticks -> 9999. Next tick -> timeout=1, DONE, digits 9999. Separately, react press on a tick cycle at 0005 -> result 0005, not 0006.
6. Reset mid-GO at count 0042 with react held high -> next cycle all outputs at reset values. After release, react still high produces no edge; state stays IDLE.
